// File: rtl/clk_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_gen_pkg
//   Shared types and constants for clock_pulse_generator and its sub-blocks.
//   - mono_state_t : states of the single-step (monostable) pulse FSM
//   - MODE_ASTABLE / MODE_MONO : encodings of mode_sel / mode_active
// -----------------------------------------------------------------------------
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_REL = 2'd2
  } mono_state_t;

  localparam logic MODE_ASTABLE = 1'b0;
  localparam logic MODE_MONO    = 1'b1;

endpackage : clk_gen_pkg

// File: rtl/push_debouncer.sv
// -----------------------------------------------------------------------------
// push_debouncer
//   Synchronises the raw step button into the clk domain, then debounces it:
//   a new level is accepted only after DEBOUNCE_CYCLES consecutive cycles in
//   which the synchronised input differs from the accepted level. A rising
//   edge of the accepted level produces a one-cycle press strobe.
//
//   Ports
//     clk       in   system clock (rising edge)
//     rst_n     in   asynchronous active-low reset
//     push_raw  in   raw, bouncy, asynchronous button (1 = pressed)
//     stable    out  debounced button level
//     press     out  one-cycle strobe, asserted in the first cycle stable is 1
// -----------------------------------------------------------------------------
module push_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_raw,
  output logic stable,
  output logic press
);

  // The counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    press_d = stable_d & ~stable_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= push_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule : push_debouncer

// File: rtl/clock_pulse_generator.sv
// -----------------------------------------------------------------------------
// clock_pulse_generator
//   Generates the 8-bit computer's clock (clk_out) from the fast system clock.
//     astable    : free-running square wave, half-period = max(half_period,1)
//     monostable : one PULSE_WIDTH-cycle pulse per debounced button press
//   halt only stops the clock while clk_out is low, and the mode only changes
//   while clk_out is low and the FSM is idle, so clk_out never carries a runt.
//
//   Optional feature macro: STEP_COUNT_EN adds the step_count port, a count of
//   clk_out rising edges that wraps at 2^STEP_W.
//
//   Ports
//     clk          in   system clock (rising edge)
//     rst_n        in   asynchronous active-low reset
//     push         in   raw step button (1 = pressed), asynchronous
//     mode_sel     in   0 = astable, 1 = monostable, asynchronous
//     halt         in   1 = stop the clock, asynchronous
//     half_period  in   astable half-period in clk cycles (0 treated as 1)
//     clk_out      out  generated clock, registered
//     busy         out  monostable FSM is not IDLE
//     mode_active  out  mode currently in effect
//     step_count   out  clk_out rising-edge count (STEP_COUNT_EN only)
// -----------------------------------------------------------------------------
module clock_pulse_generator
  import clk_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_WIDTH     = 4,
  parameter int DIV_WIDTH       = 8
`ifdef STEP_COUNT_EN
  ,
  parameter int STEP_W          = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 mode_sel,
  input  logic                 halt,
  input  logic [DIV_WIDTH-1:0] half_period,
  output logic                 clk_out,
  output logic                 busy,
  output logic                 mode_active
`ifdef STEP_COUNT_EN
  ,
  output logic [STEP_W-1:0]    step_count
`endif
);

  localparam int PCNT_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

  logic                 push_stable, press;
  logic                 mode_s1_q, mode_s2_q;
  logic                 halt_s1_q, halt_s2_q;
  mono_state_t          state_q, state_d;
  logic [PCNT_W-1:0]    pcnt_q, pcnt_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] h_q, h_d, h_sample;
  logic                 clk_out_q, clk_out_d;
  logic                 mode_q, mode_d;
  logic                 mode_switch, halted;

  push_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_push_debouncer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_raw (push),
    .stable   (push_stable),
    .press    (press)
  );

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    cnt_d     = cnt_q;
    h_d       = h_q;
    clk_out_d = clk_out_q;
    mode_d    = mode_q;

    h_sample    = (half_period == '0) ? DIV_WIDTH'(1) : half_period;
    mode_switch = !clk_out_q && (state_q == IDLE) && (mode_s2_q != mode_q);
    // A halt request is honoured only in the low phase.
    halted      = halt_s2_q && !clk_out_q;

    if (mode_switch) begin
      // Takes priority over an astable wrap, so a switch into monostable can
      // never leave clk_out high with the FSM idle.
      mode_d = mode_s2_q;
      cnt_d  = '0;
      h_d    = h_sample;
    end else if (mode_q == MODE_ASTABLE) begin
      if (halted) begin
        // Parked at zero so release starts a full low phase.
        cnt_d = '0;
        h_d   = h_sample;
      end else if (cnt_q >= h_q - DIV_WIDTH'(1)) begin
        clk_out_d = ~clk_out_q;
        cnt_d     = '0;
        h_d       = h_sample;
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press && !halt_s2_q) begin
            state_d   = PULSE;
            pcnt_d    = '0;
            clk_out_d = 1'b1;
          end
        end
        PULSE: begin
          if (pcnt_q == PCNT_W'(PULSE_WIDTH - 1)) begin
            state_d   = WAIT_REL;
            clk_out_d = 1'b0;
          end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
          end
        end
        WAIT_REL: begin
          if (!push_stable) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_q <= MODE_ASTABLE;
      mode_s2_q <= MODE_ASTABLE;
      halt_s1_q <= 1'b0;
      halt_s2_q <= 1'b0;
      state_q   <= IDLE;
      pcnt_q    <= '0;
      cnt_q     <= '0;
      h_q       <= DIV_WIDTH'(1);
      clk_out_q <= 1'b0;
      mode_q    <= MODE_ASTABLE;
    end else begin
      mode_s1_q <= mode_sel;
      mode_s2_q <= mode_s1_q;
      halt_s1_q <= halt;
      halt_s2_q <= halt_s1_q;
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      cnt_q     <= cnt_d;
      h_q       <= h_d;
      clk_out_q <= clk_out_d;
      mode_q    <= mode_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign busy        = (state_q != IDLE);
  assign mode_active = mode_q;

`ifdef STEP_COUNT_EN
  logic [STEP_W-1:0] step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (clk_out_d && !clk_out_q) step_d = step_q + STEP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= '0;
    else        step_q <= step_d;
  end

  assign step_count = step_q;
`endif

endmodule : clock_pulse_generator

// File: tb/tb_clock_pulse_generator.sv
// -----------------------------------------------------------------------------
// tb_clock_pulse_generator
//   Self-checking bench for clock_pulse_generator (DEBOUNCE_CYCLES=4,
//   PULSE_WIDTH=3, DIV_WIDTH=8). A monitor records every completed clk_out
//   high pulse width; tests push expected widths as they drive stimulus and
//   the scoreboard pops and compares them.
// -----------------------------------------------------------------------------
module tb_clock_pulse_generator;

  localparam int DEB = 4;
  localparam int PW  = 3;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push;
  logic          mode_sel;
  logic          halt;
  logic [DW-1:0] half_period;
  logic          clk_out;
  logic          busy;
  logic          mode_active;
`ifdef STEP_COUNT_EN
  logic [15:0]   step_count;
`endif

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int obs_q[$];
  int hi_run = 0;

  always #5 clk = ~clk;

  clock_pulse_generator #(
    .DEBOUNCE_CYCLES (DEB),
    .PULSE_WIDTH     (PW),
    .DIV_WIDTH       (DW)
`ifdef STEP_COUNT_EN
    ,
    .STEP_W          (16)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .mode_sel    (mode_sel),
    .halt        (halt),
    .half_period (half_period),
    .clk_out     (clk_out),
    .busy        (busy),
    .mode_active (mode_active)
`ifdef STEP_COUNT_EN
    ,
    .step_count  (step_count)
`endif
  );

  // Pulse-width monitor, sampling on the falling edge of clk.
  always @(negedge clk) begin
    if (!rst_n) begin
      hi_run <= 0;
    end else if (clk_out) begin
      hi_run <= hi_run + 1;
    end else if (hi_run > 0) begin
      obs_q.push_back(hi_run);
      hi_run <= 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_flush();
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic sb_drain(input string name);
    int e, o;
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s pulse count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s pulse width: got %0d expected %0d", name, o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // Waits for a full high phase and the following low phase; -1 on timeout.
  task automatic measure(output int hi, output int lo);
    int n;
    hi = -1; lo = -1;
    for (n = 0; n < 300 && clk_out; n++) @(negedge clk);
    for (n = 0; n < 300 && !clk_out; n++) @(negedge clk);
    if (!clk_out) return;
    hi = 0;
    for (n = 0; n < 300 && clk_out; n++) begin hi++; @(negedge clk); end
    lo = 0;
    for (n = 0; n < 300 && !clk_out; n++) begin lo++; @(negedge clk); end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (clk_out !== 1'b0) begin bad++; $display("FAIL reset clk_out: got %b expected 0", clk_out); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b expected 0", busy); end
    total++;
    if (mode_active !== 1'b0) begin bad++; $display("FAIL reset mode_active: got %b expected 0", mode_active); end
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_bounce();
    int n;
    mode_sel = 1'b1;
    for (n = 0; n < 100 && !mode_active; n++) @(negedge clk);
    total++;
    if (mode_active !== 1'b1) begin bad++; $display("FAIL mono entry mode_active: got %b expected 1", mode_active); end
    cyc(5);
    sb_flush();
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; cyc(2);
      push = 1'b0; cyc(2);
    end
    push = 1'b1;
    exp_q.push_back(PW);
    cyc(20);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL bounce busy while held: got %b expected 1", busy); end
    push = 1'b0;
    n = 0;
    while (busy && n < 30) begin @(posedge clk); #1; n++; end
    total++;
    if (n != 2 + DEB + 1) begin bad++; $display("FAIL bounce busy release cycles: got %0d expected %0d", n, 2 + DEB + 1); end
    cyc(5);
    sb_drain("bounce");
  endtask

  task automatic test_hold_repress();
    sb_flush();
    cyc(1);
    push = 1'b1;
    exp_q.push_back(PW);
    cyc(50);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL hold busy: got %b expected 1", busy); end
    push = 1'b0;
    cyc(15);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL hold busy after release: got %b expected 0", busy); end
    push = 1'b1;
    exp_q.push_back(PW);
    cyc(15);
    push = 1'b0;
    cyc(15);
    sb_drain("hold_repress");
  endtask

  task automatic test_astable();
    int n, hi, lo;
    mode_sel = 1'b0;
    for (n = 0; n < 100 && mode_active; n++) @(negedge clk);
    total++;
    if (mode_active !== 1'b0) begin bad++; $display("FAIL astable entry mode_active: got %b expected 0", mode_active); end
    measure(hi, lo);
    total++;
    if (hi != 5 || lo != 5) begin bad++; $display("FAIL astable h5 phases: got hi=%0d lo=%0d expected 5/5", hi, lo); end
    cyc(1);
    half_period = '0;
    cyc(12);
    measure(hi, lo);
    total++;
    if (hi != 1 || lo != 1) begin bad++; $display("FAIL astable h0 phases: got hi=%0d lo=%0d expected 1/1", hi, lo); end
    cyc(1);
    half_period = DW'(5);
    cyc(12);
    measure(hi, lo);
    total++;
    if (hi != 5 || lo != 5) begin bad++; $display("FAIL astable h5 restore: got hi=%0d lo=%0d expected 5/5", hi, lo); end
  endtask

  task automatic test_halt();
    int n, highs;
    for (n = 0; n < 100 && clk_out; n++) @(negedge clk);
    for (n = 0; n < 100 && !clk_out; n++) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(5);
    @(posedge clk); #1;
    halt = 1'b1;
    cyc(10);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (clk_out) highs++;
    end
    total++;
    if (highs != 0) begin bad++; $display("FAIL halt clk_out high cycles while halted: got %0d expected 0", highs); end
    sb_drain("halt_high_phase");
    @(posedge clk); #1;
    halt = 1'b0;
    n = 0;
    while (!clk_out && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (n != 2 + 5) begin bad++; $display("FAIL halt release to rise: got %0d expected %0d", n, 2 + 5); end
  endtask

  task automatic test_mode_switch();
    int n;
    for (n = 0; n < 100 && clk_out; n++) @(negedge clk);
    for (n = 0; n < 100 && !clk_out; n++) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(5);
    @(posedge clk); #1;
    mode_sel = 1'b1;
    cyc(2);
    total++;
    if (mode_active !== 1'b0) begin bad++; $display("FAIL switch mode_active during high: got %b expected 0", mode_active); end
    for (n = 0; n < 50 && !mode_active; n++) @(negedge clk);
    total++;
    if (mode_active !== 1'b1 || clk_out !== 1'b0) begin
      bad++;
      $display("FAIL switch after fall: got mode_active=%b clk_out=%b expected 1/0", mode_active, clk_out);
    end
    cyc(2);
    push = 1'b1;
    exp_q.push_back(PW);
    cyc(15);
    push = 1'b0;
    cyc(15);
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] < PW) begin bad++; $display("FAIL switch runt pulse: got %0d expected >= %0d", obs_q[i], PW); end
    end
    sb_drain("mode_switch");
  endtask

  task automatic test_reset_mid_pulse();
    int n, busy_seen;
    push = 1'b1;
    for (n = 0; n < 50 && !clk_out; n++) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (clk_out !== 1'b0) begin bad++; $display("FAIL reset mid-pulse clk_out: got %b expected 0", clk_out); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset mid-pulse busy: got %b expected 0", busy); end
    push = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    total++;
    if (busy_seen != 0) begin bad++; $display("FAIL reset mid-pulse busy after release: got %0d cycles expected 0", busy_seen); end
`ifdef STEP_COUNT_EN
    begin
      logic [15:0] s0;
      for (n = 0; n < 100 && !mode_active; n++) @(negedge clk);
      cyc(5);
      s0 = step_count;
      for (int p = 0; p < 3; p++) begin
        push = 1'b1; cyc(15);
        push = 1'b0; cyc(15);
      end
      total++;
      if (step_count - s0 !== 16'd3) begin bad++; $display("FAIL step_count delta: got %0d expected 3", step_count - s0); end
    end
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    push        = 1'b0;
    mode_sel    = 1'b0;
    halt        = 1'b0;
    half_period = DW'(5);
    test_reset();
    test_bounce();
    test_hold_repress();
    test_astable();
    test_halt();
    test_mode_switch();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_clock_pulse_generator
